// File: rtl/req_err_capture_if.sv
// Compare-channel strobes, capture readout and status bundle for req_err_capture.
// err_ts exists only when ERR_TIMESTAMP_EN is defined.
interface req_err_capture_if #(
    parameter int NCH  = 8,
    parameter int DW   = 64,
    parameter int SELW = 4,
    parameter int CNTW = 16,
    parameter int TSW  = 32
);
    logic [NCH-1:0]    err_strb;
    logic [NCH*DW-1:0] expc_bus;
    logic [NCH*DW-1:0] seen_bus;
    logic              clr;
    logic [SELW-1:0]   err_sel;
    logic [DW-1:0]     expc_err;
    logic [DW-1:0]     seen_err;
    logic [SELW-1:0]   err_chan;
    logic              err_flag;
    logic [NCH-1:0]    chan_err;
    logic [CNTW-1:0]   err_cnt;
`ifdef ERR_TIMESTAMP_EN
    logic [TSW-1:0]    err_ts;
`endif

    modport master (
        output err_strb, expc_bus, seen_bus, clr, err_sel,
`ifdef ERR_TIMESTAMP_EN
        input  err_ts,
`endif
        input  expc_err, seen_err, err_chan, err_flag, chan_err, err_cnt
    );

    modport slave (
        input  err_strb, expc_bus, seen_bus, clr, err_sel,
`ifdef ERR_TIMESTAMP_EN
        output err_ts,
`endif
        output expc_err, seen_err, err_chan, err_flag, chan_err, err_cnt
    );
endinterface

// File: rtl/req_err_capture.sv
// Sticky first-error capture per compare channel with registered readout mux.
// Optional ERR_TIMESTAMP_EN adds a free-running timestamp latched on first error.
module req_err_capture #(
    parameter int NCH  = 8,
    parameter int DW   = 64,
    parameter int SELW = 4,
    parameter int CNTW = 16,
    parameter int TSW  = 32
) (
    input  logic            clk,
    input  logic            reset,
    req_err_capture_if.slave bus
);
    localparam int SW = CNTW + SELW + 1;
    localparam logic [SW-1:0] CMAX = SW'({CNTW{1'b1}});

    logic [DW-1:0]   cap_expc_q [NCH];
    logic [DW-1:0]   cap_expc_d [NCH];
    logic [DW-1:0]   cap_seen_q [NCH];
    logic [DW-1:0]   cap_seen_d [NCH];
    logic [NCH-1:0]  chan_err_q, chan_err_d;
    logic            err_flag_q, err_flag_d;
    logic [SELW-1:0] err_chan_q, err_chan_d;
    logic [CNTW-1:0] err_cnt_q, err_cnt_d;
    logic [DW-1:0]   expc_err_q, expc_err_d;
    logic [DW-1:0]   seen_err_q, seen_err_d;
    logic [SELW-1:0] first_code;
    logic [SELW-1:0] rd_code;
    logic [SW-1:0]   pc;
    logic [SW-1:0]   sum;
    logic            first_hit;

    always_comb begin
        first_code = '0;
        pc         = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bus.err_strb[k]) first_code = SELW'(k + 1);
        end
        for (int k = 0; k < NCH; k++) begin
            pc = pc + SW'(bus.err_strb[k]);
        end
        sum       = SW'(err_cnt_q) + pc;
        first_hit = !bus.clr && !err_flag_q && (|bus.err_strb);
    end

    always_comb begin
        chan_err_d = chan_err_q;
        err_flag_d = err_flag_q;
        err_chan_d = err_chan_q;
        err_cnt_d  = err_cnt_q;
        for (int k = 0; k < NCH; k++) begin
            cap_expc_d[k] = cap_expc_q[k];
            cap_seen_d[k] = cap_seen_q[k];
        end
        if (bus.clr) begin
            chan_err_d = '0;
            err_flag_d = 1'b0;
            err_chan_d = '0;
            err_cnt_d  = '0;
            for (int k = 0; k < NCH; k++) begin
                cap_expc_d[k] = '0;
                cap_seen_d[k] = '0;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                if (bus.err_strb[k] && !chan_err_q[k]) begin
                    cap_expc_d[k] = bus.expc_bus[k*DW +: DW];
                    cap_seen_d[k] = bus.seen_bus[k*DW +: DW];
                    chan_err_d[k] = 1'b1;
                end
            end
            if (first_hit) begin
                err_flag_d = 1'b1;
                err_chan_d = first_code;
            end
            err_cnt_d = (sum > CMAX) ? CNTW'(CMAX) : CNTW'(sum);
        end
    end

    // Select 0 follows the first failing channel; err_chan is 0 until one exists
    always_comb begin
        rd_code    = (bus.err_sel == '0) ? err_chan_q : bus.err_sel;
        expc_err_d = '0;
        seen_err_d = '0;
        for (int k = 0; k < NCH; k++) begin
            if (rd_code == SELW'(k + 1)) begin
                expc_err_d = cap_expc_q[k];
                seen_err_d = cap_seen_q[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_err_q <= '0;
            err_flag_q <= 1'b0;
            err_chan_q <= '0;
            err_cnt_q  <= '0;
            expc_err_q <= '0;
            seen_err_q <= '0;
            for (int k = 0; k < NCH; k++) begin
                cap_expc_q[k] <= '0;
                cap_seen_q[k] <= '0;
            end
        end else begin
            chan_err_q <= chan_err_d;
            err_flag_q <= err_flag_d;
            err_chan_q <= err_chan_d;
            err_cnt_q  <= err_cnt_d;
            expc_err_q <= expc_err_d;
            seen_err_q <= seen_err_d;
            for (int k = 0; k < NCH; k++) begin
                cap_expc_q[k] <= cap_expc_d[k];
                cap_seen_q[k] <= cap_seen_d[k];
            end
        end
    end

`ifdef ERR_TIMESTAMP_EN
    logic [TSW-1:0] ts_q, ts_d;
    logic [TSW-1:0] err_ts_q, err_ts_d;

    always_comb begin
        ts_d     = ts_q + TSW'(1);
        err_ts_d = err_ts_q;
        if (bus.clr) err_ts_d = '0;
        else if (first_hit) err_ts_d = ts_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q     <= '0;
            err_ts_q <= '0;
        end else begin
            ts_q     <= ts_d;
            err_ts_q <= err_ts_d;
        end
    end

    assign bus.err_ts = err_ts_q;
`endif

    assign bus.expc_err = expc_err_q;
    assign bus.seen_err = seen_err_q;
    assign bus.err_chan = err_chan_q;
    assign bus.err_flag = err_flag_q;
    assign bus.chan_err = chan_err_q;
    assign bus.err_cnt  = err_cnt_q;
endmodule

// File: tb/tb_req_err_capture.sv
// Directed checks of req_err_capture: capture, first-error, counter,
// clear priority, readout mux and asynchronous reset.
module tb_req_err_capture;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    req_err_capture_if #(.CNTW(16)) bus ();
    req_err_capture_if #(.CNTW(4))  sbus ();

    req_err_capture #(.CNTW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    req_err_capture #(.CNTW(4)) dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".expc"}, bus.expc_err, 64'h0);
        chk({tag, ".seen"}, bus.seen_err, 64'h0);
        chk({tag, ".chan"}, 64'(bus.err_chan), 64'h0);
        chk({tag, ".flag"}, 64'(bus.err_flag), 64'h0);
        chk({tag, ".cerr"}, 64'(bus.chan_err), 64'h0);
        chk({tag, ".cnt"}, 64'(bus.err_cnt), 64'h0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.err_strb = '0;
        bus.expc_bus = '0;
        bus.seen_bus = '0;
        bus.clr = 1'b0;
        bus.err_sel = '0;
        sbus.err_strb = '0;
        sbus.expc_bus = '0;
        sbus.seen_bus = '0;
        sbus.clr = 1'b0;
        sbus.err_sel = '0;
        #1;
        chk_zero("reset");
        chk("reset.scnt", 64'(sbus.err_cnt), 64'h0);
        tick();
        tick();
        reset = 1'b0;

        for (int s = 0; s < 16; s++) begin
            bus.err_sel = 4'(s);
            tick();
            chk("sel_idle.expc", bus.expc_err, 64'h0);
            chk("sel_idle.seen", bus.seen_err, 64'h0);
        end

        // single error on channel 2
        bus.err_strb = 8'h04;
        bus.expc_bus[2*64 +: 64] = 64'hA5;
        bus.seen_bus[2*64 +: 64] = 64'hA4;
        bus.err_sel = 4'd3;
        tick();
        bus.err_strb = '0;
        chk("ch2.cnt1", 64'(bus.err_cnt), 64'd1);
        tick();
        chk("ch2.expc", bus.expc_err, 64'hA5);
        chk("ch2.seen", bus.seen_err, 64'hA4);
        chk("ch2.chan", 64'(bus.err_chan), 64'd3);
        chk("ch2.flag", 64'(bus.err_flag), 64'd1);
        chk("ch2.cerr", 64'(bus.chan_err), 64'h04);

        // second strobe on channel 2 must not overwrite
        bus.err_strb = 8'h04;
        bus.expc_bus[2*64 +: 64] = 64'h11;
        bus.seen_bus[2*64 +: 64] = 64'h10;
        tick();
        bus.err_strb = '0;
        tick();
        chk("ch2b.expc", bus.expc_err, 64'hA5);
        chk("ch2b.seen", bus.seen_err, 64'hA4);
        chk("ch2b.cnt", 64'(bus.err_cnt), 64'd2);
        chk("ch2b.chan", 64'(bus.err_chan), 64'd3);

        // clear, then simultaneous strobes on 5 and 7
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("clr.cnt", 64'(bus.err_cnt), 64'd0);
        chk("clr.flag", 64'(bus.err_flag), 64'd0);
        chk("clr.cerr", 64'(bus.chan_err), 64'd0);
        chk("clr.chan", 64'(bus.err_chan), 64'd0);
        tick();
        chk("clr.expc", bus.expc_err, 64'h0);
        bus.err_strb = 8'hA0;
        bus.expc_bus[5*64 +: 64] = 64'h55;
        bus.seen_bus[5*64 +: 64] = 64'h54;
        bus.expc_bus[7*64 +: 64] = 64'h77;
        bus.seen_bus[7*64 +: 64] = 64'h76;
        bus.err_sel = 4'd0;
        tick();
        bus.err_strb = '0;
        tick();
        chk("dual.chan", 64'(bus.err_chan), 64'd6);
        chk("dual.cerr", 64'(bus.chan_err), 64'hA0);
        chk("dual.cnt", 64'(bus.err_cnt), 64'd2);
        chk("dual.sel0e", bus.expc_err, 64'h55);
        chk("dual.sel0s", bus.seen_err, 64'h54);
        bus.err_sel = 4'd8;
        tick();
        chk("dual.sel8e", bus.expc_err, 64'h77);
        chk("dual.sel8s", bus.seen_err, 64'h76);
        bus.err_sel = 4'd9;
        tick();
        chk("dual.sel9", bus.expc_err, 64'h0);
        bus.err_sel = 4'd6;
        tick();
        chk("dual.sel6", bus.expc_err, 64'h55);
        bus.err_sel = 4'd3;
        tick();
        chk("dual.sel3", bus.expc_err, 64'h0);

        // clr has priority over a simultaneous strobe
        bus.clr = 1'b1;
        bus.err_strb = 8'h01;
        bus.expc_bus[63:0] = 64'hDEAD;
        bus.seen_bus[63:0] = 64'hBEEF;
        bus.err_sel = 4'd1;
        tick();
        bus.clr = 1'b0;
        bus.err_strb = '0;
        tick();
        chk_zero("clrprio");

        // saturating counter on the CNTW=4 instance
        for (int i = 0; i < 3; i++) begin
            sbus.err_strb = 8'h01;
            tick();
        end
        sbus.err_strb = '0;
        chk("sat.cnt3", 64'(sbus.err_cnt), 64'd3);
        for (int i = 0; i < 17; i++) begin
            sbus.err_strb = 8'h02;
            tick();
        end
        sbus.err_strb = '0;
        chk("sat.cnt20", 64'(sbus.err_cnt), 64'd15);
        sbus.err_strb = 8'hFF;
        tick();
        sbus.err_strb = '0;
        chk("sat.burst", 64'(sbus.err_cnt), 64'd15);
        sbus.clr = 1'b1;
        tick();
        sbus.clr = 1'b0;
        sbus.err_strb = 8'hFF;
        tick();
        tick();
        sbus.err_strb = '0;
        chk("sat.pop", 64'(sbus.err_cnt), 64'd15);

        // asynchronous reset mid-capture
        bus.err_strb = 8'h10;
        bus.expc_bus[4*64 +: 64] = 64'h44;
        bus.err_sel = 4'd5;
        tick();
        bus.err_strb = '0;
        tick();
        chk("pre_rst.expc", bus.expc_err, 64'h44);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("async_rst");
        chk("async_rst.scnt", 64'(sbus.err_cnt), 64'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst.expc", bus.expc_err, 64'h0);

`ifdef ERR_TIMESTAMP_EN
        // counter is 0 after reset, so the first error at counter 100
        // falls on the 101st edge after release
        reset = 1'b1;
        #1;
        reset = 1'b0;
        chk("ts.reset", 64'(bus.err_ts), 64'd0);
        for (int i = 0; i < 100; i++) tick();
        bus.err_strb = 8'h01;
        tick();
        bus.err_strb = '0;
        chk("ts.first", 64'(bus.err_ts), 64'd100);
        bus.err_strb = 8'h02;
        tick();
        bus.err_strb = '0;
        chk("ts.hold", 64'(bus.err_ts), 64'd100);
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        chk("ts.clr", 64'(bus.err_ts), 64'd0);
        bus.err_strb = 8'h04;
        tick();
        bus.err_strb = '0;
        chk("ts.free", 64'(bus.err_ts), 64'd103);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
